sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//  Producer side of the compressor's W/K word interface: generates message-schedule words W[0..63] for one 512-bit block.
//  Loads the 16 block words serially, then streams W[t] with index t, one word per cycle under valid/ready.
//  Sits between block padding/buffering and MOD_COMPRESSOR, replacing the 64-entry W memory with a 16-entry window.
// PARAMETERS
//  WORD_W   32  word width; fixed by SHA-256, other values unsupported
//  ROUNDS   64  words streamed per block
// PORTS
//  CLK         in   1   clock; all state updates on posedge
//  RESET       in   1   synchronous, active-high reset
//  LOAD_VALID  in   1   LOAD_DATA holds a block word
//  LOAD_READY  out  1   block accepts load words
//  LOAD_DATA   in   32  block word, big-endian, M[0] first
//  W_VALID     out  1   W_OUT/W_IDX valid
//  W_READY     in   1   compressor consumes the word
//  W_OUT       out  32  schedule word W[W_IDX]
//  W_IDX       out  6   round index t (0..63)
//  W_LAST      out  1   high with W_VALID when W_IDX==63
//  K_OUT       out  32  round constant K[W_IDX] (SHA256_SCHED_KOUT_EN builds only)
// BEHAVIOUR
//  Reset: state IDLE, LOAD_READY=0, W_VALID=0, W_OUT=0, W_IDX=0, W_LAST=0, K_OUT=0, load count=0. RESET wins over all other inputs.
//  FSM: IDLE -> LOAD (next cycle, LOAD_READY=1) -> STREAM (after 16th load handshake) -> IDLE (after t=63 handshake).
//  LOAD: word accepted on LOAD_VALID&LOAD_READY, written to buf[cnt], cnt++. On 16th accept: LOAD_READY=0 next cycle; W_VALID=1,
//   W_IDX=0, W_OUT=M[0] that same next cycle (load-to-first-word latency 1 clock).
//  STREAM: W handshake = W_VALID&W_READY. On handshake W_IDX increments and next word is presented the following cycle;
//   sustained throughput 1 word/clock with W_READY held high. W_OUT, W_IDX, W_LAST, K_OUT stay stable while W_VALID&!W_READY.
//  Words: t<16 -> W[t]=buf[t]. t>=16 -> W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16], all adds mod 2^32 (carries dropped),
//   result overwrites buf[t mod 16]. Only the low 4 index bits select buf slots (circular window).
//   s0(x)=ROTR7^ROTR18^SHR3, s1(x)=ROTR17^ROTR19^SHR10.
//  Next word computed combinationally from buffer and registered on handshake; no extra pipeline stage.
//  End of block: handshake at t=63 -> W_VALID=0, W_LAST=0, W_IDX=0, state IDLE; LOAD_READY=1 one cycle later (LOAD state).
//   Minimum gap between blocks: 2 clocks plus the 16 load cycles.
//  LOAD_VALID while not LOAD_READY is ignored; W_READY while !W_VALID is ignored.
//  RESET mid-LOAD or mid-STREAM: partial block discarded, all outputs to reset values next cycle; buffer contents don't-care.
// CONFIGURATION
//  SHA256_SCHED_KOUT_EN defined: K ROM instantiated; K_OUT=K[W_IDX] registered alongside W_OUT with identical timing/stall rules.
//  Undefined: no K_OUT port and no ROM; the compressor supplies K itself.
// STRUCTURE
//  sha256_pkg: 64-entry K constant table, WORD_W/ROUNDS localparams, s0/s1 functions, FSM state encoding.
//  Sub-module sha256_k_rom (6-bit addr -> 32-bit K, combinational), instantiated only under SHA256_SCHED_KOUT_EN.
//  16x32 buffer, 4-bit load count, 6-bit round count kept in this module.
// TESTING
//  1 Block "abc" (M0=0x61626380, M1..M14=0, M15=0x00000018), W_READY=1 -> W0=0x61626380, W16=0x61626380, W17=0x000F0000,
//    W18=0x7DA86405, W_LAST only at t=63, 64 words in 64 consecutive clocks.
//  2 All-zero block -> all 64 W_OUT=0; W_IDX 0..63 in order; LOAD_READY returns 2 clocks after final handshake.
//  3 "Hello world!" block (M0=0x48656C6C, M15=0x00000060), random W_READY stalls -> output sequence equal to golden model,
//    outputs unchanged during every stalled cycle.
//  4 RESET asserted at t=30 of STREAM -> next cycle W_VALID=0, W_IDX=0; a following "abc" load reproduces scenario 1 exactly.
//  5 LOAD_VALID gapped (every other cycle) during LOAD -> W_VALID rises 1 clock after 16th accept; extra LOAD_VALID in STREAM ignored.
//  6 SHA256_SCHED_KOUT_EN build -> K_OUT=0x428A2F98 at t=0, 0xC67178F2 at t=63, aligned with W_OUT under stalls.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared definitions for the SHA-256 message-schedule block.
//   WORD_W / ROUNDS  : word width and rounds per block
//   sched_state_e    : scheduler FSM encoding
//   K_TABLE          : the 64 SHA-256 round constants
//   sigma0 / sigma1  : the small-sigma schedule functions
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROUNDS = 64;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStream
  } sched_state_e;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom: combinational SHA-256 round-constant lookup.
//   addr_i : round index 0..63
//   k_o    : K[addr_i]
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr_i,
  output logic [31:0] k_o
);

  assign k_o = K_TABLE[addr_i];

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: serial-load SHA-256 message schedule with a 16-word circular window.
// Loads M[0..15] over LOAD_VALID/LOAD_READY, then streams W[0..63] one per W handshake.
//   CLK, RESET         : clock, synchronous active-high reset
//   LOAD_VALID/READY   : block-word load handshake, LOAD_DATA carries M[0] first
//   W_VALID/READY      : schedule-word handshake
//   W_OUT, W_IDX       : W[t] and t
//   W_LAST             : marks t == 63
//   K_OUT              : K[W_IDX], present only when SHA256_SCHED_KOUT_EN is defined
// Configuration macro: SHA256_SCHED_KOUT_EN adds the K ROM and K_OUT port.
module sha256_msg_schedule #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  input  logic [WORD_W-1:0] LOAD_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [WORD_W-1:0] W_OUT,
  output logic [5:0]        W_IDX,
  output logic              W_LAST
`ifdef SHA256_SCHED_KOUT_EN
  ,
  output logic [WORD_W-1:0] K_OUT
`endif
);
  import sha256_pkg::*;

  localparam logic [5:0] LastIdx = 6'(ROUNDS - 1);

  sched_state_e      state_q;
  logic [3:0]        load_cnt_q;
  logic [WORD_W-1:0] buf_q [16];
  logic              load_ready_q;
  logic              w_valid_q;
  logic [WORD_W-1:0] w_out_q;
  logic [5:0]        w_idx_q;
  logic              w_last_q;

  logic [5:0]        next_idx;
  logic [3:0]        next_slot;
  logic [WORD_W-1:0] next_word;

  assign next_idx  = w_idx_q + 6'd1;
  assign next_slot = next_idx[3:0];

  // Window holds W[t-16..t-1]; slot t mod 16 still holds W[t-16] until overwritten.
  always_comb begin
    next_word = buf_q[next_slot];
    if (next_idx >= 6'd16) begin
      next_word = sigma1(buf_q[next_slot - 4'd2]) + buf_q[next_slot - 4'd7]
                + sigma0(buf_q[next_slot - 4'd15]) + buf_q[next_slot];
    end
  end

`ifdef SHA256_SCHED_KOUT_EN
  logic [5:0]        k_addr;
  logic [WORD_W-1:0] k_rom_word;
  logic [WORD_W-1:0] k_out_q;

  // While loading, the first word to present is t=0; while streaming, the next one.
  assign k_addr = w_valid_q ? next_idx : 6'd0;

  sha256_k_rom u_k_rom (
    .addr_i (k_addr),
    .k_o    (k_rom_word)
  );

  assign K_OUT = k_out_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      load_cnt_q   <= '0;
      load_ready_q <= 1'b0;
      w_valid_q    <= 1'b0;
      w_out_q      <= '0;
      w_idx_q      <= '0;
      w_last_q     <= 1'b0;
`ifdef SHA256_SCHED_KOUT_EN
      k_out_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q      <= StLoad;
          load_ready_q <= 1'b1;
          load_cnt_q   <= '0;
        end
        StLoad: begin
          if (LOAD_VALID) begin
            buf_q[load_cnt_q] <= LOAD_DATA;
            load_cnt_q        <= load_cnt_q + 4'd1;
            if (load_cnt_q == 4'd15) begin
              state_q      <= StStream;
              load_ready_q <= 1'b0;
              w_valid_q    <= 1'b1;
              w_idx_q      <= '0;
              w_last_q     <= 1'b0;
              w_out_q      <= buf_q[0];
`ifdef SHA256_SCHED_KOUT_EN
              k_out_q      <= k_rom_word;
`endif
            end
          end
        end
        StStream: begin
          // W_VALID is always high in this state, so W_READY alone is the handshake.
          if (W_READY) begin
            if (w_idx_q == LastIdx) begin
              state_q   <= StIdle;
              w_valid_q <= 1'b0;
              w_last_q  <= 1'b0;
              w_idx_q   <= '0;
            end else begin
              w_idx_q          <= next_idx;
              w_out_q          <= next_word;
              w_last_q         <= (next_idx == LastIdx);
              buf_q[next_slot] <= next_word;
`ifdef SHA256_SCHED_KOUT_EN
              k_out_q          <= k_rom_word;
`endif
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign LOAD_READY = load_ready_q;
  assign W_VALID    = w_valid_q;
  assign W_OUT      = w_out_q;
  assign W_IDX      = w_idx_q;
  assign W_LAST     = w_last_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        LOAD_VALID = 1'b0;
  logic [31:0] LOAD_DATA = '0;
  logic        W_READY = 1'b0;
  logic        LOAD_READY, W_VALID, W_LAST;
  logic [31:0] W_OUT;
  logic [5:0]  W_IDX;
`ifdef SHA256_SCHED_KOUT_EN
  logic [31:0] K_OUT;
`endif

  int checks = 0;
  int errors = 0;
  int stream_cycles = 0;
  logic [31:0] blk [16];
  logic [31:0] gw  [64];
  logic [31:0] cap [64];

  sha256_msg_schedule dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_READY (LOAD_READY),
    .LOAD_DATA  (LOAD_DATA),
    .W_VALID    (W_VALID),
    .W_READY    (W_READY),
    .W_OUT      (W_OUT),
    .W_IDX      (W_IDX),
    .W_LAST     (W_LAST)
`ifdef SHA256_SCHED_KOUT_EN
    ,
    .K_OUT      (K_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full 64-entry expansion straight from the recurrence.
  task automatic build_golden();
    for (int i = 0; i < 16; i++) gw[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      gw[i] = (rotr(gw[i-2], 17) ^ rotr(gw[i-2], 19) ^ (gw[i-2] >> 10)) + gw[i-7]
            + (rotr(gw[i-15], 7) ^ rotr(gw[i-15], 18) ^ (gw[i-15] >> 3)) + gw[i-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_golden();
  endtask

  task automatic load_block(input bit gapped, input string name);
    int i = 0;
    int cyc = 0;
    while (i < 16 && cyc < 200) begin
      @(negedge CLK);
      if (gapped && (cyc % 2 == 1)) begin
        LOAD_VALID = 1'b0;
      end else begin
        LOAD_VALID = 1'b1;
        LOAD_DATA  = blk[i];
      end
      if (LOAD_VALID && LOAD_READY) i++;
      cyc++;
    end
    checks++;
    if (i != 16) begin
      errors++; $display("FAIL %s load_timeout accepted %0d want 16", name, i);
    end
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    checks++;
    if (W_VALID !== 1'b1) begin
      errors++; $display("FAIL %s first_word_latency w_valid %b want 1", name, W_VALID);
    end
    checks++;
    if (W_IDX !== 6'd0) begin
      errors++; $display("FAIL %s first_idx %0d want 0", name, W_IDX);
    end
    checks++;
    if (LOAD_READY !== 1'b0) begin
      errors++; $display("FAIL %s load_ready_drop %b want 0", name, LOAD_READY);
    end
  endtask

  // Entered on a negedge with W[0] presented.
  task automatic stream_block(input bit stalls, input bit lv_noise, input int stop_at,
                              input string name);
    int t = 0;
    int cyc = 0;
    bit was_stall = 1'b0;
    logic [31:0] prev_w;
    logic [5:0]  prev_i;
`ifdef SHA256_SCHED_KOUT_EN
    logic [31:0] prev_k;
`endif
    while (t < stop_at && cyc < 1000) begin
      checks++;
      if (W_VALID !== 1'b1) begin
        errors++; $display("FAIL %s w_valid t=%0d got %b want 1", name, t, W_VALID);
      end
      checks++;
      if (W_IDX !== t[5:0]) begin
        errors++; $display("FAIL %s w_idx got %0d want %0d", name, W_IDX, t);
      end
      checks++;
      if (W_OUT !== gw[t]) begin
        errors++; $display("FAIL %s w_out t=%0d got %h want %h", name, t, W_OUT, gw[t]);
      end
      checks++;
      if (W_LAST !== (t == 63)) begin
        errors++; $display("FAIL %s w_last t=%0d got %b want %b", name, t, W_LAST, t == 63);
      end
      checks++;
      if (LOAD_READY !== 1'b0) begin
        errors++; $display("FAIL %s load_ready_in_stream t=%0d got %b want 0", name, t, LOAD_READY);
      end
      if (was_stall) begin
        checks++;
        if (W_OUT !== prev_w || W_IDX !== prev_i) begin
          errors++;
          $display("FAIL %s stall_hold got %h/%0d want %h/%0d", name, W_OUT, W_IDX, prev_w, prev_i);
        end
      end
`ifdef SHA256_SCHED_KOUT_EN
      if (t == 0) begin
        checks++;
        if (K_OUT !== 32'h428a2f98) begin
          errors++; $display("FAIL %s k_out_t0 got %h want 428a2f98", name, K_OUT);
        end
      end
      if (t == 63) begin
        checks++;
        if (K_OUT !== 32'hc67178f2) begin
          errors++; $display("FAIL %s k_out_t63 got %h want c67178f2", name, K_OUT);
        end
      end
      if (was_stall) begin
        checks++;
        if (K_OUT !== prev_k) begin
          errors++; $display("FAIL %s k_stall_hold got %h want %h", name, K_OUT, prev_k);
        end
      end
      prev_k = K_OUT;
`endif
      cap[t] = W_OUT;
      prev_w = W_OUT;
      prev_i = W_IDX;
      W_READY = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (lv_noise) begin
        LOAD_VALID = 1'b1;
        LOAD_DATA  = $urandom;
      end
      was_stall = !W_READY;
      if (W_READY) t++;
      cyc++;
      @(negedge CLK);
    end
    W_READY = 1'b0;
    LOAD_VALID = 1'b0;
    stream_cycles = cyc;
    checks++;
    if (t < stop_at) begin
      errors++; $display("FAIL %s stream_timeout reached t=%0d want %0d", name, t, stop_at);
    end
    if (stop_at == 64) begin
      checks++;
      if (W_VALID !== 1'b0 || W_IDX !== 6'd0 || W_LAST !== 1'b0 || LOAD_READY !== 1'b0) begin
        errors++;
        $display("FAIL %s end_of_block valid/idx/last/ready %b/%0d/%b/%b want 0/0/0/0",
                 name, W_VALID, W_IDX, W_LAST, LOAD_READY);
      end
      @(negedge CLK);
      checks++;
      if (LOAD_READY !== 1'b1) begin
        errors++; $display("FAIL %s load_ready_return got %b want 1", name, LOAD_READY);
      end
    end
  endtask

  task automatic check_abc_words(input string name);
    checks++;
    if (cap[0] !== 32'h61626380) begin
      errors++; $display("FAIL %s w0 got %h want 61626380", name, cap[0]);
    end
    checks++;
    if (cap[16] !== 32'h61626380) begin
      errors++; $display("FAIL %s w16 got %h want 61626380", name, cap[16]);
    end
    checks++;
    if (cap[17] !== 32'h000f0000) begin
      errors++; $display("FAIL %s w17 got %h want 000f0000", name, cap[17]);
    end
    checks++;
    if (cap[18] !== 32'h7da86405) begin
      errors++; $display("FAIL %s w18 got %h want 7da86405", name, cap[18]);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (LOAD_READY !== 1'b0 || W_VALID !== 1'b0 || W_LAST !== 1'b0) begin
      errors++;
      $display("FAIL reset flags ready/valid/last %b/%b/%b want 0/0/0", LOAD_READY, W_VALID, W_LAST);
    end
    checks++;
    if (W_OUT !== 32'h0 || W_IDX !== 6'd0) begin
      errors++; $display("FAIL reset data w_out/w_idx %h/%0d want 0/0", W_OUT, W_IDX);
    end
`ifdef SHA256_SCHED_KOUT_EN
    checks++;
    if (K_OUT !== 32'h0) begin
      errors++; $display("FAIL reset k_out got %h want 0", K_OUT);
    end
`endif
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (LOAD_READY !== 1'b1) begin
      errors++; $display("FAIL reset_to_load load_ready got %b want 1", LOAD_READY);
    end
  endtask

  task automatic test_abc();
    set_abc();
    load_block(1'b0, "abc");
    stream_block(1'b0, 1'b0, 64, "abc");
    checks++;
    if (stream_cycles != 64) begin
      errors++; $display("FAIL abc throughput cycles %0d want 64", stream_cycles);
    end
    check_abc_words("abc");
  endtask

  task automatic test_zero();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    build_golden();
    load_block(1'b0, "zero");
    stream_block(1'b0, 1'b0, 64, "zero");
    checks++;
    if (cap[63] !== 32'h0 || cap[40] !== 32'h0) begin
      errors++; $display("FAIL zero late_words w40/w63 %h/%h want 0/0", cap[40], cap[63]);
    end
  endtask

  task automatic test_hello_stalls();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h48656c6c;
    blk[1]  = 32'h6f20776f;
    blk[2]  = 32'h726c6421;
    blk[3]  = 32'h80000000;
    blk[15] = 32'h00000060;
    build_golden();
    load_block(1'b0, "hello");
    stream_block(1'b1, 1'b0, 64, "hello");
  endtask

  task automatic test_reset_mid_stream();
    set_abc();
    load_block(1'b0, "rst_mid");
    stream_block(1'b0, 1'b0, 30, "rst_mid");
    RESET = 1'b1;
    W_READY = 1'b1;
    @(negedge CLK);
    W_READY = 1'b0;
    checks++;
    if (W_VALID !== 1'b0 || W_IDX !== 6'd0 || W_LAST !== 1'b0 || W_OUT !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid outputs valid/idx/last/out %b/%0d/%b/%h want 0/0/0/0",
               W_VALID, W_IDX, W_LAST, W_OUT);
    end
    checks++;
    if (LOAD_READY !== 1'b0) begin
      errors++; $display("FAIL rst_mid load_ready got %b want 0", LOAD_READY);
    end
    RESET = 1'b0;
    load_block(1'b0, "rst_reload");
    stream_block(1'b0, 1'b0, 64, "rst_reload");
    check_abc_words("rst_reload");
  endtask

  task automatic test_gapped_load_noise();
    set_abc();
    load_block(1'b1, "gapped");
    stream_block(1'b1, 1'b1, 64, "gapped");
    check_abc_words("gapped");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_hello_stalls();
    test_reset_mid_stream();
    test_gapped_load_noise();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
